// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-priority arbiter for one shared SRAM-style port with bounded inst starvation
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        bus_en,
  output logic [3:0]  bus_wen,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_STREAK);

  logic [3:0] r_streak;
  logic       r_resp_inst;
  logic       r_resp_data;

  logic       w_streak_full;
  logic       w_inst_gnt;
  logic       w_data_gnt;
  logic [3:0] w_streak_nxt;

  assign w_streak_full = (r_streak == LP_MAX_STREAK);

  // Data wins unless the waiting fetch has already been passed over MAX_STREAK times.
  always_comb begin
    w_inst_gnt = 1'b0;
    w_data_gnt = 1'b0;
    if (rst) begin
      if (data_req && !(inst_req && w_streak_full)) begin
        w_data_gnt = 1'b1;
      end else if (inst_req) begin
        w_inst_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    w_streak_nxt = r_streak;
    if (!inst_req || w_inst_gnt) begin
      w_streak_nxt = 4'd0;
    end else if (w_data_gnt && !w_streak_full) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_streak    <= 4'd0;
      r_resp_inst <= 1'b0;
      r_resp_data <= 1'b0;
    end else begin
      r_streak    <= w_streak_nxt;
      r_resp_inst <= w_inst_gnt;
      r_resp_data <= w_data_gnt;
    end
  end

  assign inst_gnt  = w_inst_gnt;
  assign data_gnt  = w_data_gnt;
  assign bus_en    = w_inst_gnt | w_data_gnt;
  assign bus_wen   = w_data_gnt ? data_wen : 4'd0;
  assign bus_addr  = w_inst_gnt ? inst_addr : data_addr;
  assign bus_wdata = data_wdata;

  // Gated by rst so a response in flight when reset asserts never surfaces.
  assign inst_rvalid = r_resp_inst & rst;
  assign data_rvalid = r_resp_data & rst;
  assign inst_rdata  = bus_rdata;
  assign data_rdata  = bus_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_req1;
  logic [31:0] inst_addr;
  logic        data_req, data_req1;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] bus_rdata;

  logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid, bus_en;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wen;

  logic        inst_gnt_1, inst_rvalid_1, data_gnt_1, data_rvalid_1, bus_en_1;
  logic [31:0] inst_rdata_1, data_rdata_1, bus_addr_1, bus_wdata_1;
  logic [3:0]  bus_wen_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_STREAK(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .bus_en(bus_en), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  mem_port_arbiter #(.MAX_STREAK(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req1), .inst_addr(inst_addr), .inst_gnt(inst_gnt_1),
    .inst_rvalid(inst_rvalid_1), .inst_rdata(inst_rdata_1),
    .data_req(data_req1), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt_1), .data_rvalid(data_rvalid_1),
    .data_rdata(data_rdata_1), .bus_en(bus_en_1), .bus_wen(bus_wen_1),
    .bus_addr(bus_addr_1), .bus_wdata(bus_wdata_1), .bus_rdata(bus_rdata)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; inst_req = 1'b1; data_req = 1'b1; inst_req1 = 1'b1; data_req1 = 1'b1;
    data_wen = 4'hF; inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; bus_rdata = 32'h0;
    step; step; sample;
    checks++; if (inst_gnt !== 1'b0) begin errors++; $display("FAIL reset_inst_gnt: got %b expected 0", inst_gnt); end
    checks++; if (data_gnt !== 1'b0) begin errors++; $display("FAIL reset_data_gnt: got %b expected 0", data_gnt); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL reset_bus_en: got %b expected 0", bus_en); end
    checks++; if (bus_wen !== 4'h0) begin errors++; $display("FAIL reset_bus_wen: got %h expected 0", bus_wen); end
    checks++; if (inst_rvalid !== 1'b0) begin errors++; $display("FAIL reset_inst_rvalid: got %b expected 0", inst_rvalid); end
    checks++; if (data_rvalid !== 1'b0) begin errors++; $display("FAIL reset_data_rvalid: got %b expected 0", data_rvalid); end
    checks++; if (bus_en_1 !== 1'b0) begin errors++; $display("FAIL reset_bus_en_1: got %b expected 0", bus_en_1); end
    step;
    rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; inst_req1 = 1'b0; data_req1 = 1'b0; data_wen = 4'h0;
    sample;
    checks++; if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid: got %b%b expected 00", inst_rvalid, data_rvalid); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL idle_bus_en: got %b expected 0", bus_en); end
  endtask

  task automatic test_single_read;
    step;
    inst_req = 1'b1; inst_addr = 32'h1FC0_0000;
    sample;
    checks++; if (inst_gnt !== 1'b1) begin errors++; $display("FAIL read_inst_gnt: got %b expected 1", inst_gnt); end
    checks++; if (data_gnt !== 1'b0) begin errors++; $display("FAIL read_data_gnt: got %b expected 0", data_gnt); end
    checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL read_bus_en: got %b expected 1", bus_en); end
    checks++; if (bus_wen !== 4'h0) begin errors++; $display("FAIL read_bus_wen: got %h expected 0", bus_wen); end
    checks++; if (bus_addr !== 32'h1FC0_0000) begin errors++; $display("FAIL read_bus_addr: got %h expected 1fc00000", bus_addr); end
    step;
    inst_req = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    sample;
    checks++; if (inst_rvalid !== 1'b1) begin errors++; $display("FAIL read_inst_rvalid: got %b expected 1", inst_rvalid); end
    checks++; if (inst_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_inst_rdata: got %h expected deadbeef", inst_rdata); end
    checks++; if (data_rvalid !== 1'b0) begin errors++; $display("FAIL read_data_rvalid: got %b expected 0", data_rvalid); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL read_idle_bus_en: got %b expected 0", bus_en); end
    step; sample;
    checks++; if (inst_rvalid !== 1'b0) begin errors++; $display("FAIL read_rvalid_once: got %b expected 0", inst_rvalid); end
  endtask

  task automatic test_data_write;
    step;
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h1FAF_0010; data_wdata = 32'h1234_5678;
    sample;
    checks++; if (data_gnt !== 1'b1) begin errors++; $display("FAIL write_data_gnt: got %b expected 1", data_gnt); end
    checks++; if (inst_gnt !== 1'b0) begin errors++; $display("FAIL write_inst_gnt: got %b expected 0", inst_gnt); end
    checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL write_bus_en: got %b expected 1", bus_en); end
    checks++; if (bus_wen !== 4'b0011) begin errors++; $display("FAIL write_bus_wen: got %h expected 3", bus_wen); end
    checks++; if (bus_addr !== 32'h1FAF_0010) begin errors++; $display("FAIL write_bus_addr: got %h expected 1faf0010", bus_addr); end
    checks++; if (bus_wdata !== 32'h1234_5678) begin errors++; $display("FAIL write_bus_wdata: got %h expected 12345678", bus_wdata); end
    step;
    data_req = 1'b0; data_wen = 4'h0;
    sample;
    checks++; if (data_rvalid !== 1'b1) begin errors++; $display("FAIL write_data_rvalid: got %b expected 1", data_rvalid); end
    checks++; if (inst_rvalid !== 1'b0) begin errors++; $display("FAIL write_inst_rvalid: got %b expected 0", inst_rvalid); end
    step; sample;
    checks++; if (data_rvalid !== 1'b0) begin errors++; $display("FAIL write_rvalid_once: got %b expected 0", data_rvalid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] rd [3];
    addrs = '{32'h100, 32'h104, 32'h108};
    rd    = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hC3C3_0003};
    for (int k = 0; k < 4; k++) begin
      step;
      data_wen = 4'h0;
      if (k < 3) begin data_req = 1'b1; data_addr = addrs[k]; end
      else data_req = 1'b0;
      if (k > 0) bus_rdata = rd[k-1];
      sample;
      if (k < 3) begin
        checks++; if (data_gnt !== 1'b1) begin errors++; $display("FAIL b2b_data_gnt[%0d]: got %b expected 1", k, data_gnt); end
        checks++; if (bus_addr !== addrs[k]) begin errors++; $display("FAIL b2b_bus_addr[%0d]: got %h expected %h", k, bus_addr, addrs[k]); end
      end
      if (k > 0) begin
        checks++; if (data_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_data_rvalid[%0d]: got %b expected 1", k, data_rvalid); end
        checks++; if (data_rdata !== rd[k-1]) begin errors++; $display("FAIL b2b_data_rdata[%0d]: got %h expected %h", k, data_rdata, rd[k-1]); end
      end
    end
    step; sample;
    checks++; if (data_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_rvalid_end: got %b expected 0", data_rvalid); end
  endtask

  task automatic test_contention;
    logic exp_i [10];
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 11; k++) begin
      step;
      inst_req = (k < 10); data_req = (k < 10);
      data_wen = 4'h0; inst_addr = 32'h2000 + 32'(k); data_addr = 32'h3000 + 32'(k);
      sample;
      if (k < 10) begin
        checks++; if (inst_gnt !== exp_i[k]) begin errors++; $display("FAIL cont_inst_gnt[%0d]: got %b expected %b", k, inst_gnt, exp_i[k]); end
        checks++; if (data_gnt !== ~exp_i[k]) begin errors++; $display("FAIL cont_data_gnt[%0d]: got %b expected %b", k, data_gnt, ~exp_i[k]); end
      end
      if (k > 0) begin
        checks++; if (inst_rvalid !== exp_i[k-1]) begin errors++; $display("FAIL cont_inst_rvalid[%0d]: got %b expected %b", k, inst_rvalid, exp_i[k-1]); end
        checks++; if (data_rvalid !== ~exp_i[k-1]) begin errors++; $display("FAIL cont_data_rvalid[%0d]: got %b expected %b", k, data_rvalid, ~exp_i[k-1]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    step;
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    sample;
    checks++; if (inst_gnt !== 1'b1) begin errors++; $display("FAIL rmid_first_gnt: got %b expected 1", inst_gnt); end
    step;
    rst = 1'b0;
    sample;
    checks++; if (inst_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_dropped_rvalid: got %b expected 0", inst_rvalid); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL rmid_bus_en: got %b expected 0", bus_en); end
    checks++; if (inst_gnt !== 1'b0) begin errors++; $display("FAIL rmid_gnt_in_reset: got %b expected 0", inst_gnt); end
    step;
    rst = 1'b1;
    sample;
    checks++; if (inst_gnt !== 1'b1) begin errors++; $display("FAIL rmid_release_gnt: got %b expected 1", inst_gnt); end
    checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL rmid_release_bus_en: got %b expected 1", bus_en); end
    checks++; if (inst_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_release_rvalid: got %b expected 0", inst_rvalid); end
    step;
    inst_req = 1'b0;
    sample;
    checks++; if (inst_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_new_rvalid: got %b expected 1", inst_rvalid); end
    step; sample;
    checks++; if (inst_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid_end: got %b expected 0", inst_rvalid); end
  endtask

  task automatic test_max_streak1;
    logic exp_i [6];
    exp_i = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      step;
      inst_req1 = (k < 6); data_req1 = (k < 6); data_wen = 4'h0;
      sample;
      if (k < 6) begin
        checks++; if (inst_gnt_1 !== exp_i[k]) begin errors++; $display("FAIL ms1_inst_gnt[%0d]: got %b expected %b", k, inst_gnt_1, exp_i[k]); end
        checks++; if (data_gnt_1 !== ~exp_i[k]) begin errors++; $display("FAIL ms1_data_gnt[%0d]: got %b expected %b", k, data_gnt_1, ~exp_i[k]); end
      end
      if (k > 0) begin
        checks++; if (inst_rvalid_1 !== exp_i[k-1]) begin errors++; $display("FAIL ms1_inst_rvalid[%0d]: got %b expected %b", k, inst_rvalid_1, exp_i[k-1]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_data_write;
    test_back_to_back;
    test_contention;
    test_reset_mid;
    test_max_streak1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
